// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding and default
// aux wait limit.
package dmem_arb_pkg;
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CORE = 2'd1;
  localparam logic [1:0] OWN_AUX  = 2'd2;

  localparam int DEFAULT_MAX_WAIT = 4;
  localparam int WAIT_W = 4;
endpackage

// File: rtl/sat_wait_ctr.sv
// Saturating up-counter with synchronous clear; at_max flags the limit value.
module sat_wait_ctr #(
  parameter int W   = 4,
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_max
);
  localparam logic [W-1:0] MAX_L = W'(MAX);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_L)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign at_max = (cnt == MAX_L);
endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core load/store port and
// an auxiliary requester; core has priority, aux is forced in after MAX_WAIT.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          c_read,
  input  logic          c_write,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_stall,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic [DW-1:0] a_rdata,
  output logic          a_rvalid,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic          m_read,
  output logic          m_write,
  input  logic [DW-1:0] m_rdata
);
  // Aux handshake: a_req is the valid and a_gnt the ready. a_req, a_we,
  // a_addr and a_wdata stay stable until the cycle a_gnt is high; the access
  // happens in that cycle and a new request may follow in the next one.
  logic       c_req;
  logic       wait_max;
  logic [1:0] owner;

  assign c_req = c_read | c_write;

  sat_wait_ctr #(
    .W   (WAIT_W),
    .MAX (MAX_WAIT)
  ) u_wait (
    .clk    (clock),
    .rst_n  (reset),
    .clr    (!a_req || a_gnt),
    .inc    (a_req),
    .at_max (wait_max)
  );

  always_comb begin
    owner = OWN_NONE;
    if (a_req && (wait_max || !c_req)) begin
      owner = OWN_AUX;
    end else if (c_req) begin
      owner = OWN_CORE;
    end
  end

  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    m_read  = 1'b0;
    m_write = 1'b0;
    case (owner)
      OWN_CORE: begin
        m_addr  = c_addr;
        m_wdata = c_wdata;
        m_read  = c_read;
        m_write = c_write;
      end
      OWN_AUX: begin
        m_addr  = a_addr;
        m_wdata = a_wdata;
        m_read  = !a_we;
        m_write = a_we;
      end
      default: ;
    endcase
  end

  assign a_gnt   = (owner == OWN_AUX);
  // A stalled core store is simply not issued; the core repeats it next cycle.
  assign c_stall = c_req && (owner == OWN_AUX);
  assign c_rdata = m_rdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_rdata  <= '0;
      a_rvalid <= 1'b0;
    end else begin
      a_rvalid <= a_gnt && !a_we;
      if (a_gnt && !a_we) begin
        a_rdata <= m_rdata;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of single-cycle arbitration vectors plus
// hand-written multi-cycle sequences; aux read data checked via a queue.
module tb_dmem_arbiter;
  logic        clock;
  logic        reset;
  logic        c_read, c_write;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        c_stall;
  logic        a_req, a_we;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        a_gnt, a_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_read, m_write;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .c_read   (c_read),
    .c_write  (c_write),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_rdata  (c_rdata),
    .c_stall  (c_stall),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_rdata  (a_rdata),
    .a_rvalid (a_rvalid),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_read   (m_read),
    .m_write  (m_write),
    .m_rdata  (m_rdata)
  );

  // clock / reset and the dmem model (combinational read, clocked write)
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] dmem [0:255];
  wire  [7:0]  widx = m_addr[9:2];
  assign m_rdata = dmem[widx];
  always @(posedge clock) if (m_write) dmem[widx] <= m_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_core(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    c_read = r; c_write = w; c_addr = a; c_wdata = d;
  endtask

  task automatic set_aux(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    a_req = r; a_we = w; a_addr = a; a_wdata = d;
  endtask

  task automatic idle();
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    set_aux(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // scoreboard: every a_rvalid pulse consumes one expected aux read value
  always @(negedge clock) begin
    if (reset && a_rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_rvalid actual=%h expected=none", a_rdata);
      end else begin
        chk("sb_a_rdata", a_rdata, exp_q.pop_front());
      end
    end
  end

  typedef struct {
    logic cr, cw; logic [31:0] ca, cd;
    logic ar, awe; logic [31:0] aa, ad;
    logic er, ew; logic [31:0] ea, ed;
    logic eg, es; logic [31:0] erd;
  } vec_t;
  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h00, 32'h0,    1'b0, 1'b0, 32'h00, 32'h0,
                1'b1, 1'b0, 32'h00, 32'h0,    1'b0, 1'b0, 32'h335e};
    vecs[1] = '{1'b0, 1'b1, 32'h40, 32'h1111, 1'b0, 1'b0, 32'h00, 32'h0,
                1'b0, 1'b1, 32'h40, 32'h1111, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h00, 32'h0,    1'b1, 1'b1, 32'h44, 32'h2222,
                1'b0, 1'b1, 32'h44, 32'h2222, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h00, 32'h0,    1'b1, 1'b0, 32'h30, 32'h0,
                1'b1, 1'b0, 32'h30, 32'h0,    1'b1, 1'b0, 32'h1234};
    vecs[4] = '{1'b1, 1'b0, 32'h04, 32'h0,    1'b1, 1'b1, 32'h48, 32'h9999,
                1'b1, 1'b0, 32'h04, 32'h0,    1'b0, 1'b0, 32'habcd};
    vecs[5] = '{1'b0, 1'b1, 32'h4c, 32'h3333, 1'b1, 1'b0, 32'h30, 32'h0,
                1'b0, 1'b1, 32'h4c, 32'h3333, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 32'h50, 32'h77,   1'b0, 1'b1, 32'h54, 32'h88,
                1'b0, 1'b0, 32'h00, 32'h0,    1'b0, 1'b0, 32'h335e};

    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    dmem[0]  = 32'h335e;
    dmem[1]  = 32'habcd;
    dmem[12] = 32'h1234;

    // reset state
    reset = 1'b0;
    idle();
    #1;
    chk("rst_a_rvalid", {31'h0, a_rvalid}, 32'h0);
    chk("rst_a_rdata", a_rdata, 32'h0);
    chk("rst_a_gnt", {31'h0, a_gnt}, 32'h0);
    chk("rst_m_read", {31'h0, m_read}, 32'h0);
    #12 reset = 1'b1;
    tick();

    // table: single-cycle arbitration with the wait counter at zero
    for (int i = 0; i < 7; i++) begin
      set_core(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd);
      set_aux(vecs[i].ar, vecs[i].awe, vecs[i].aa, vecs[i].ad);
      #1;
      chk($sformatf("v%0d_m_read", i), {31'h0, m_read}, {31'h0, vecs[i].er});
      chk($sformatf("v%0d_m_write", i), {31'h0, m_write}, {31'h0, vecs[i].ew});
      chk($sformatf("v%0d_m_addr", i), m_addr, vecs[i].ea);
      chk($sformatf("v%0d_m_wdata", i), m_wdata, vecs[i].ed);
      chk($sformatf("v%0d_a_gnt", i), {31'h0, a_gnt}, {31'h0, vecs[i].eg});
      chk($sformatf("v%0d_c_stall", i), {31'h0, c_stall}, {31'h0, vecs[i].es});
      chk($sformatf("v%0d_c_rdata", i), c_rdata, vecs[i].erd);
      if (vecs[i].ar && !vecs[i].awe && vecs[i].eg) exp_q.push_back(32'h1234);
      tick();
      idle();
      tick();
    end

    // aux only: write then read back 0x18
    set_aux(1'b1, 1'b1, 32'h18, 32'hdead);
    #1;
    chk("auxw_gnt", {31'h0, a_gnt}, 32'h1);
    chk("auxw_m_write", {31'h0, m_write}, 32'h1);
    tick();
    set_aux(1'b1, 1'b0, 32'h18, 32'h0);
    #1;
    chk("auxr_gnt", {31'h0, a_gnt}, 32'h1);
    chk("auxr_m_read", {31'h0, m_read}, 32'h1);
    exp_q.push_back(32'hdead);
    tick();
    idle();
    #1;
    chk("auxr_rvalid", {31'h0, a_rvalid}, 32'h1);
    chk("auxr_rdata", a_rdata, 32'hdead);
    tick();
    chk("auxr_rvalid_drop", {31'h0, a_rvalid}, 32'h0);
    chk("auxr_rdata_hold", a_rdata, 32'hdead);
    tick();

    // continuous core traffic: forced grant at cycle 4, next one at cycle 9
    set_core(1'b1, 1'b0, 32'h0, 32'h0);
    set_aux(1'b1, 1'b0, 32'h18, 32'h0);
    for (int k = 0; k < 10; k++) begin
      if (k == 5) set_aux(1'b1, 1'b1, 32'h44, 32'h5555);
      #1;
      chk($sformatf("conf%0d_gnt", k), {31'h0, a_gnt}, (k == 4 || k == 9) ? 32'h1 : 32'h0);
      chk($sformatf("conf%0d_stall", k), {31'h0, c_stall}, (k == 4 || k == 9) ? 32'h1 : 32'h0);
      if (k == 4) exp_q.push_back(32'hdead);
      tick();
    end
    idle();
    chk("conf_aux_wr", dmem[17], 32'h5555);
    tick();

    // core idle gap lets aux in without a stall
    for (int k = 0; k < 3; k++) begin
      set_core(k < 2, 1'b0, 32'h0, 32'h0);
      set_aux(1'b1, 1'b1, 32'h48, 32'h6666);
      #1;
      chk($sformatf("gap%0d_gnt", k), {31'h0, a_gnt}, (k == 2) ? 32'h1 : 32'h0);
      chk($sformatf("gap%0d_stall", k), {31'h0, c_stall}, 32'h0);
      tick();
    end
    idle();
    tick();

    // stalled store is dropped, then retried
    set_core(1'b1, 1'b0, 32'h0, 32'h0);
    set_aux(1'b1, 1'b0, 32'h18, 32'h0);
    for (int k = 0; k < 4; k++) tick();
    set_core(1'b0, 1'b1, 32'h20, 32'h407f);
    #1;
    chk("sst_stall", {31'h0, c_stall}, 32'h1);
    chk("sst_gnt", {31'h0, a_gnt}, 32'h1);
    chk("sst_m_write", {31'h0, m_write}, 32'h0);
    exp_q.push_back(32'hdead);
    tick();
    chk("sst_mem_unchanged", dmem[8], 32'h0);
    set_aux(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("sst_retry_stall", {31'h0, c_stall}, 32'h0);
    chk("sst_retry_m_write", {31'h0, m_write}, 32'h1);
    chk("sst_retry_m_addr", m_addr, 32'h20);
    tick();
    chk("sst_mem_written", dmem[8], 32'h407f);
    idle();
    tick();

    // reset mid-wait restarts the counter
    set_core(1'b1, 1'b0, 32'h0, 32'h0);
    set_aux(1'b1, 1'b0, 32'h18, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("rw%0d_gnt", k), {31'h0, a_gnt}, 32'h0);
      tick();
    end
    #2 reset = 1'b0;
    #1;
    chk("rw_rst_rdata", a_rdata, 32'h0);
    chk("rw_rst_rvalid", {31'h0, a_rvalid}, 32'h0);
    #2 reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rwpost%0d_gnt", k), {31'h0, a_gnt}, (k == 4) ? 32'h1 : 32'h0);
      if (k == 4) exp_q.push_back(32'hdead);
      tick();
    end
    idle();
    tick();
    tick();

    chk("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
